xbus_arbiter: RTL and testbench
===============================

# xbus_arbiter

Arbitrates the single external memory bus between two requesters:
- the CPU bus sequencer (MOVX/MOVC and opcode fetches);
- the monitor/debug port (program/external read/write commands).

The block runs one fixed 8-phase access per grant. It drives the shared chip enables, strobes, address and write data, captures read data, and returns a one-cycle acknowledge to the owner. It sits between the core/monitor logic and the external pins.

## Interface
Parameters:
- ADDR_W, 16, external address width
- DATA_W, 8, external data width

Ports:
- Clock_In  in  1  sole clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- cpu_req / mon_req  in  1  access request; held with stable fields until matching ack
- cpu_wr / mon_wr  in  1  1 = write, 0 = read
- cpu_prog / mon_prog  in  1  1 = program space (PCE_n), 0 = data space (DCE_n)
- cpu_addr / mon_addr  in  ADDR_W  access address
- cpu_wdata / mon_wdata  in  DATA_W  write data
- cpu_ack / mon_ack  out  1  one-cycle completion pulse
- cpu_rdata / mon_rdata  out  DATA_W  read result; held until that requester's next read completes
- XA  out  ADDR_W  external address
- XD_out  out  DATA_W  external write data
- XD_oe  out  1  data pad output enable
- XD_in  in  DATA_W  external read data
- PCE_n, DCE_n, OE_n, WR_n  out  1  active-low program enable, data enable, read strobe, write strobe
- busy  out  1  access or recovery in progress
- owner  out  1  0 = CPU, 1 = monitor; valid while busy

## Operation
- **States:** IDLE, ACCESS (3-bit phase counter 0..7), RECOVER.
- **IDLE:**
  - If any req is high, pick a winner and latch its wr/prog/addr/wdata.
  - Go to ACCESS with phase = 0; set busy and owner.
  - With no req, stay in IDLE.
- **Arbitration:** two-way round-robin on `last_owner`.
  - A single requester always wins.
  - If both request, the one not served last wins.
  - `last_owner` resets to monitor, so the CPU wins the first tie.
  - `last_owner` updates at grant.
- **ACCESS:**
  - All outputs are registered and driven from the latched fields.
  - XA is valid for phases 0–7.
  - The selected CE_n is low for phases 0–7. The other CE_n stays high.
  - Read: OE_n low for phases 0–7; XD_in is sampled on the edge that ends phase 7.
  - Write: XD_oe high and XD_out valid for phases 0–7; WR_n low for phases 1–6 only.
  - Phase increments each cycle; after phase 7, go to RECOVER.
- **RECOVER:**
  - All strobes and enables are high; XD_oe is 0.
  - The owner's ack is 1 and its rdata is updated (reads only).
  - busy stays 1. Next state is IDLE.
  - The requester must drop req or present a new request by the following cycle. The one-cycle RECOVER keeps the held req from being re-granted.
- **Requester changes:**
  - Dropping req before grant: no access occurs.
  - Dropping req after grant: the access still completes and ack still pulses.
- **Reset mid-access:** at the next edge all enables/strobes go high, XD_oe goes 0, no ack is issued, and the state returns to IDLE.
- **Reset values:**
  - PCE_n = DCE_n = OE_n = WR_n = 1.
  - XA = 0, XD_out = 0, XD_oe = 0.
  - cpu_ack = mon_ack = 0; cpu_rdata = mon_rdata = 0.
  - busy = 0, owner = 0; `last_owner` = monitor.

## Timing
- req is seen in IDLE at cycle T:
  - phases 0–7 occupy T+1..T+8;
  - ack is high at T+9;
  - IDLE is re-entered at T+10.
- Throughput is one access per 10 cycles under continuous requests, alternating owners when both request.
- Write data hold: XD_oe rises with the CE_n edge and drops with it. WR_n is inset by one cycle on each side.
- cpu_rdata / mon_rdata are valid in the same cycle as the ack.
- Requests may change in the ack cycle with no effect; the arbiter only samples req in IDLE.

## Structure
- Package `xbus_pkg` holds:
  - the state enum {IDLE, ACCESS, RECOVER};
  - owner encoding OWN_CPU = 0, OWN_MON = 1;
  - phase constants PH_WR_ON = 1, PH_WR_OFF = 6, PH_LAST = 7.
- One sub-module, `xbus_rr_pick`: a combinational two-way round-robin picker with inputs {req[1:0], last_owner} and outputs {grant_valid, grant_id}.

## Test plan
- **CPU data read:** cpu_req, wr = 0, prog = 0, addr = 0x1234, XD_in = 0xA5 → DCE_n and OE_n low for 8 cycles, XA = 0x1234, cpu_ack at T+9 with cpu_rdata = 0xA5; PCE_n and WR_n stay high.
- **Monitor program write:** mon_req, wr = 1, prog = 1, addr = 0x0040, wdata = 0x3C → PCE_n low for phases 0–7, WR_n low for phases 1–6 only, XD_out = 0x3C with XD_oe high for 8 cycles; mon_ack at T+9.
- **Simultaneous requests from reset:** CPU served first, then monitor. With both held, grants alternate CPU, mon, CPU at 10-cycle spacing; each ack appears exactly once per access.
- **Requester drops req:**
  - Drop after grant (phase 3): access completes, ack still pulses.
  - Drop while the other owner is busy: never granted.
- **Reset during write:** RESET at phase 4 → next cycle all _n outputs are 1, XD_oe = 0, no ack, busy = 0. A subsequent request completes normally.

Source files
------------

// File: rtl/xbus_pkg.sv
// rtl/xbus_pkg.sv - shared types and constants for the external bus arbiter
package xbus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } xbus_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_MON = 1'b1;

  localparam logic [2:0] PH_WR_ON  = 3'd1;
  localparam logic [2:0] PH_WR_OFF = 3'd6;
  localparam logic [2:0] PH_LAST   = 3'd7;

endpackage

// File: rtl/xbus_rr_pick.sv
// rtl/xbus_rr_pick.sv - combinational two-way round-robin picker
module xbus_rr_pick
  import xbus_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

  assign o_grant_valid = |i_req;

  // A lone requester wins outright; on a tie the one not served last wins
  always_comb begin
    o_grant_id = OWN_CPU;
    case (i_req)
      2'b01:   o_grant_id = OWN_CPU;
      2'b10:   o_grant_id = OWN_MON;
      2'b11:   o_grant_id = ~i_last_owner;
      default: o_grant_id = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/xbus_arbiter.sv
// rtl/xbus_arbiter.sv - CPU/monitor arbiter running fixed 8-phase external bus accesses
module xbus_arbiter
  import xbus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
)
(
  input  logic              Clock_In,
  input  logic              RESET,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_prog,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              mon_req,
  input  logic              mon_wr,
  input  logic              mon_prog,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_wdata,
  output logic              mon_ack,
  output logic [DATA_W-1:0] mon_rdata,
  output logic [ADDR_W-1:0] XA,
  output logic [DATA_W-1:0] XD_out,
  output logic              XD_oe,
  input  logic [DATA_W-1:0] XD_in,
  output logic              PCE_n,
  output logic              DCE_n,
  output logic              OE_n,
  output logic              WR_n,
  output logic              busy,
  output logic              owner
);

  xbus_state_t       r_state;
  logic [2:0]        r_phase;
  logic              r_wr;
  logic              r_last_owner;
  logic [ADDR_W-1:0] r_xa;
  logic [DATA_W-1:0] r_xd_out;
  logic              r_xd_oe;
  logic              r_pce_n;
  logic              r_dce_n;
  logic              r_oe_n;
  logic              r_wr_n;
  logic              r_cpu_ack;
  logic              r_mon_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_mon_rdata;
  logic              r_busy;
  logic              r_owner;

  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_sel_wr;
  logic              w_sel_prog;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [2:0]        w_phase_nxt;
  logic              w_wr_strobe_nxt;

  xbus_rr_pick u_pick (
    .i_req         ({mon_req, cpu_req}),
    .i_last_owner  (r_last_owner),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Fields of whichever requester the picker selected
  assign w_sel_wr    = (w_grant_id == OWN_MON) ? mon_wr    : cpu_wr;
  assign w_sel_prog  = (w_grant_id == OWN_MON) ? mon_prog  : cpu_prog;
  assign w_sel_addr  = (w_grant_id == OWN_MON) ? mon_addr  : cpu_addr;
  assign w_sel_wdata = (w_grant_id == OWN_MON) ? mon_wdata : cpu_wdata;

  // WR_n is computed one phase ahead so the strobe lands registered on its phase
  assign w_phase_nxt     = r_phase + 3'd1;
  assign w_wr_strobe_nxt = r_wr && (w_phase_nxt >= PH_WR_ON) && (w_phase_nxt <= PH_WR_OFF);

  // Access sequencer: grant in IDLE, eight phases in ACCESS, ack in RECOVER
  always_ff @(posedge Clock_In) begin
    if (RESET) begin
      r_state      <= IDLE;
      r_phase      <= 3'd0;
      r_wr         <= 1'b0;
      r_last_owner <= OWN_MON;
      r_xa         <= '0;
      r_xd_out     <= '0;
      r_xd_oe      <= 1'b0;
      r_pce_n      <= 1'b1;
      r_dce_n      <= 1'b1;
      r_oe_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_cpu_ack    <= 1'b0;
      r_mon_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_mon_rdata  <= '0;
      r_busy       <= 1'b0;
      r_owner      <= OWN_CPU;
    end else begin
      r_cpu_ack <= 1'b0;
      r_mon_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_state      <= ACCESS;
            r_phase      <= 3'd0;
            r_busy       <= 1'b1;
            r_owner      <= w_grant_id;
            r_last_owner <= w_grant_id;
            r_wr         <= w_sel_wr;
            r_xa         <= w_sel_addr;
            r_xd_out     <= w_sel_wdata;
            r_pce_n      <= ~w_sel_prog;
            r_dce_n      <= w_sel_prog;
            r_oe_n       <= w_sel_wr;
            r_xd_oe      <= w_sel_wr;
            r_wr_n       <= 1'b1;
          end
        end
        ACCESS: begin
          if (r_phase == PH_LAST) begin
            r_state <= RECOVER;
            r_pce_n <= 1'b1;
            r_dce_n <= 1'b1;
            r_oe_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_xd_oe <= 1'b0;
            if (r_owner == OWN_MON) begin
              r_mon_ack <= 1'b1;
              if (!r_wr) r_mon_rdata <= XD_in;
            end else begin
              r_cpu_ack <= 1'b1;
              if (!r_wr) r_cpu_rdata <= XD_in;
            end
          end else begin
            r_phase <= w_phase_nxt;
            r_wr_n  <= ~w_wr_strobe_nxt;
          end
        end
        RECOVER: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign XA        = r_xa;
  assign XD_out    = r_xd_out;
  assign XD_oe     = r_xd_oe;
  assign PCE_n     = r_pce_n;
  assign DCE_n     = r_dce_n;
  assign OE_n      = r_oe_n;
  assign WR_n      = r_wr_n;
  assign cpu_ack   = r_cpu_ack;
  assign mon_ack   = r_mon_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign mon_rdata = r_mon_rdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb/tb_xbus_arbiter.sv - scoreboard bench for the external bus arbiter
module tb_xbus_arbiter;

  logic        Clock_In = 1'b0;
  logic        RESET;
  logic        cpu_req, cpu_wr, cpu_prog;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        mon_req, mon_wr, mon_prog;
  logic [15:0] mon_addr;
  logic [7:0]  mon_wdata;
  logic        mon_ack;
  logic [7:0]  mon_rdata;
  logic [15:0] XA;
  logic [7:0]  XD_out;
  logic        XD_oe;
  logic [7:0]  XD_in;
  logic        PCE_n, DCE_n, OE_n, WR_n, busy, owner;

  typedef struct {
    bit          own;
    bit          wr;
    bit          prog;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } exp_t;

  exp_t sb[$];
  int   ack_cycles[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   ph = 0;
  int   start_cyc = 0;
  bit   prev_busy = 0;
  bit   xd_force_en = 0;
  logic [7:0] xd_force = 8'h00;

  xbus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .Clock_In  (Clock_In),
    .RESET     (RESET),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_prog  (cpu_prog),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mon_req   (mon_req),
    .mon_wr    (mon_wr),
    .mon_prog  (mon_prog),
    .mon_addr  (mon_addr),
    .mon_wdata (mon_wdata),
    .mon_ack   (mon_ack),
    .mon_rdata (mon_rdata),
    .XA        (XA),
    .XD_out    (XD_out),
    .XD_oe     (XD_oe),
    .XD_in     (XD_in),
    .PCE_n     (PCE_n),
    .DCE_n     (DCE_n),
    .OE_n      (OE_n),
    .WR_n      (WR_n),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 Clock_In = ~Clock_In;

  always @(posedge Clock_In) cyc <= cyc + 1;

  function automatic logic [7:0] xd_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always_comb XD_in = xd_force_en ? xd_force : xd_model(XA);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus monitor: checks pins against the head of the scoreboard every cycle
  always @(negedge Clock_In) begin
    #1;
    if (RESET) begin
      ph = 0;
      prev_busy = 0;
    end else begin
      if (busy && !prev_busy) start_cyc = cyc;
      prev_busy = busy;
      if (!PCE_n || !DCE_n) begin
        if (sb.size() == 0) begin
          check_eq("stray_access", 32'(1), 32'(0));
        end else begin
          check_eq("xa", 32'(XA), 32'(sb[0].addr));
          check_eq("pce_n", 32'(PCE_n), 32'(!sb[0].prog));
          check_eq("dce_n", 32'(DCE_n), 32'(sb[0].prog));
          check_eq("oe_n", 32'(OE_n), 32'(sb[0].wr));
          check_eq("xd_oe", 32'(XD_oe), 32'(sb[0].wr));
          check_eq("wr_n", 32'(WR_n), 32'(!(sb[0].wr && ph >= 1 && ph <= 6)));
          check_eq("owner", 32'(owner), 32'(sb[0].own));
          if (sb[0].wr) check_eq("xd_out", 32'(XD_out), 32'(sb[0].wdata));
        end
        ph++;
      end else begin
        check_eq("idle_strobes", 32'({OE_n, WR_n, XD_oe}), 32'(3'b110));
      end
      if (cpu_ack || mon_ack) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_ack", 32'({mon_ack, cpu_ack}), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("ack_who", 32'({mon_ack, cpu_ack}), e.own ? 32'(2) : 32'(1));
          check_eq("phase_count", 32'(ph), 32'(8));
          check_eq("ack_latency", 32'(cyc - start_cyc), 32'(8));
          check_eq("busy_at_ack", 32'(busy), 32'(1));
          if (!e.wr) check_eq("rdata", e.own ? 32'(mon_rdata) : 32'(cpu_rdata), 32'(e.rdata));
        end
        ack_cycles.push_back(cyc);
        ph = 0;
      end
    end
  end

  task automatic start_req(input bit who, input bit wr, input bit prog,
                           input logic [15:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.own = who; e.wr = wr; e.prog = prog; e.addr = addr; e.wdata = wdata;
    e.rdata = xd_force_en ? xd_force : xd_model(addr);
    sb.push_back(e);
    if (who) begin
      mon_wr = wr; mon_prog = prog; mon_addr = addr; mon_wdata = wdata; mon_req = 1'b1;
    end else begin
      cpu_wr = wr; cpu_prog = prog; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit who, input int budget);
    bit got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge Clock_In);
      got = who ? mon_ack : cpu_ack;
    end
    check_eq(who ? "mon_ack_seen" : "cpu_ack_seen", 32'(got), 32'(1));
  endtask

  task automatic wait_busy(input int budget);
    bit got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge Clock_In);
      got = busy;
    end
    check_eq("busy_seen", 32'(got), 32'(1));
  endtask

  initial begin
    RESET = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_prog = 0; cpu_addr = '0; cpu_wdata = '0;
    mon_req = 0; mon_wr = 0; mon_prog = 0; mon_addr = '0; mon_wdata = '0;
    repeat (3) @(negedge Clock_In);

    check_eq("rst_strobes", 32'({PCE_n, DCE_n, OE_n, WR_n}), 32'(4'hF));
    check_eq("rst_xa", 32'(XA), 32'(0));
    check_eq("rst_xd", 32'({XD_out, XD_oe}), 32'(0));
    check_eq("rst_acks", 32'({cpu_ack, mon_ack}), 32'(0));
    check_eq("rst_rdata", 32'({cpu_rdata, mon_rdata}), 32'(0));
    check_eq("rst_busy_owner", 32'({busy, owner}), 32'(0));
    RESET = 1'b0;
    @(negedge Clock_In);

    // CPU data read with a fixed read value on the pads
    xd_force_en = 1; xd_force = 8'hA5;
    start_req(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00);
    wait_ack(1'b0, 20);
    cpu_req = 1'b0;
    @(negedge Clock_In);
    xd_force_en = 0;

    // Monitor program write
    start_req(1'b1, 1'b1, 1'b1, 16'h0040, 8'h3C);
    wait_ack(1'b1, 20);
    mon_req = 1'b0;
    @(negedge Clock_In);
    check_eq("cpu_rdata_held", 32'(cpu_rdata), 32'(8'hA5));

    // Simultaneous requests straight out of reset: CPU, mon, CPU
    RESET = 1'b1;
    repeat (2) @(negedge Clock_In);
    RESET = 1'b0;
    ack_cycles.delete();
    start_req(1'b0, 1'b0, 1'b0, 16'h0100, 8'h00);
    start_req(1'b1, 1'b1, 1'b0, 16'h2222, 8'h77);
    begin
      exp_t e;
      e = sb[0];
      sb.push_back(e);
    end
    wait_ack(1'b0, 30);
    wait_ack(1'b1, 30);
    mon_req = 1'b0;
    wait_ack(1'b0, 30);
    cpu_req = 1'b0;
    @(negedge Clock_In);
    check_eq("rr_ack_count", 32'(ack_cycles.size()), 32'(3));
    if (ack_cycles.size() == 3) begin
      check_eq("rr_spacing_1", 32'(ack_cycles[1] - ack_cycles[0]), 32'(10));
      check_eq("rr_spacing_2", 32'(ack_cycles[2] - ack_cycles[1]), 32'(10));
    end

    // CPU drops req at phase 3: access still completes
    start_req(1'b0, 1'b1, 1'b0, 16'h0BEE, 8'h5D);
    wait_busy(20);
    repeat (3) @(negedge Clock_In);
    cpu_req = 1'b0;
    wait_ack(1'b0, 20);
    @(negedge Clock_In);

    // Monitor request raised and dropped while CPU owns the bus: never granted
    start_req(1'b0, 1'b0, 1'b1, 16'h4321, 8'h00);
    wait_busy(20);
    mon_wr = 1'b1; mon_prog = 1'b0; mon_addr = 16'hDEAD; mon_wdata = 8'hEE; mon_req = 1'b1;
    repeat (2) @(negedge Clock_In);
    mon_req = 1'b0;
    wait_ack(1'b0, 20);
    cpu_req = 1'b0;
    repeat (15) @(negedge Clock_In);
    check_eq("dropped_never_granted", 32'(busy), 32'(0));

    // Reset at phase 4 of a monitor write
    start_req(1'b1, 1'b1, 1'b0, 16'h00AA, 8'hC3);
    wait_busy(20);
    repeat (4) @(negedge Clock_In);
    RESET = 1'b1;
    mon_req = 1'b0;
    sb.delete();
    @(negedge Clock_In);
    check_eq("abort_strobes", 32'({PCE_n, DCE_n, OE_n, WR_n}), 32'(4'hF));
    check_eq("abort_xd_oe", 32'(XD_oe), 32'(0));
    check_eq("abort_busy", 32'(busy), 32'(0));
    check_eq("abort_acks", 32'({cpu_ack, mon_ack}), 32'(0));
    RESET = 1'b0;
    repeat (12) @(negedge Clock_In);

    // A normal access after the abort
    start_req(1'b1, 1'b0, 1'b0, 16'h5678, 8'h00);
    wait_ack(1'b1, 20);
    mon_req = 1'b0;
    repeat (3) @(negedge Clock_In);
    check_eq("mon_rdata_final", 32'(mon_rdata), 32'(xd_model(16'h5678)));
    check_eq("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
